// File: rtl/gcc_pkg.sv
// Shared constants and encodings for the GCC cross-correlation engine.
// Holds sample/frame/lag sizing, derived widths, the compute FSM state
// encoding, the ping-pong buffer flag encoding and the output saturator.
package gcc_pkg;
  localparam int DW      = 16;              // PCM sample width (signed)
  localparam int N       = 64;              // samples per frame (power of 2)
  localparam int MAX_LAG = 16;              // maximum absolute lag
  localparam int OW      = 32;              // output word width (signed)
  localparam int L       = 2*MAX_LAG + 1;   // lags per frame

  localparam int NW = $clog2(N);                // sample index width
  localparam int PW = 2*DW;                     // product width
  localparam int AW = 2*DW + NW;                // accumulator width
  localparam int KW = $clog2(MAX_LAG + 1) + 1;  // signed lag width

  // Largest / smallest OW-bit signed values, sign-extended to AW bits.
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_FLUSH,
    ST_EMIT
  } state_t;

  typedef enum logic [1:0] {
    BUF_FREE,
    BUF_FULL,
    BUF_BUSY
  } buf_flag_t;

  function automatic logic signed [OW-1:0] sat_ow(input logic signed [AW-1:0] v);
    if (v > SAT_HI) return SAT_HI[OW-1:0];
    if (v < SAT_LO) return SAT_LO[OW-1:0];
    return v[OW-1:0];
  endfunction
endpackage

// File: rtl/xcorr_mac.sv
// Sequential signed multiply-accumulate for one correlation lag.
// Pipeline: operand register -> product register -> accumulator.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr          clear accumulator (takes priority over accumulation)
//   in_valid     a/b carry a term to accumulate this cycle
//   a, b         signed operands
//   emit         register sat(acc >>> OUT_SHIFT) onto out_data
//   out_data     saturated result, held between emits
//   out_valid    one-cycle strobe, high the cycle after emit
module xcorr_mac
  import gcc_pkg::*;
#(
  parameter int OUT_SHIFT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic                 emit,
  output logic signed [OW-1:0] out_data,
  output logic                 out_valid
);
  logic signed [DW-1:0] a_q, b_q;
  logic                 v0_q, v1_q;
  logic signed [PW-1:0] prod_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_sh;

  assign acc_sh = acc_q >>> OUT_SHIFT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      a_q    <= a;
      b_q    <= b;
      v0_q   <= in_valid;
      prod_q <= PW'(a_q) * PW'(b_q);
      v1_q   <= v0_q;
      if (clr) acc_q <= '0;
      else if (v1_q) acc_q <= acc_q + $signed({{NW{prod_q[PW-1]}}, prod_q});
      out_valid <= emit;
      // emit and clr coincide at lag boundaries: the old acc is read here.
      if (emit) out_data <= sat_ow(acc_sh);
    end
  end
endmodule

// File: rtl/gcc_xcorr_engine.sv
// Frame capture into two ping-pong buffers plus a sequential time-domain
// cross-correlator over lags -MAX_LAG..+MAX_LAG.
// Handshake: pcm_valid and xcorr_done are single-cycle strobes with no
// ready/backpressure; data is valid exactly in the strobe cycle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   pcm_a, pcm_b      paired mic samples, signed, valid with pcm_valid
//   xcorr_data        correlation word for one lag, valid with xcorr_done
//   frame_busy        compute FSM not idle
//   frame_drop        pulse after the first sample of a discarded frame
module gcc_xcorr_engine
  import gcc_pkg::*;
#(
  parameter int OUT_SHIFT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] pcm_a,
  input  logic signed [DW-1:0] pcm_b,
  input  logic                 pcm_valid,
  output logic signed [OW-1:0] xcorr_data,
  output logic                 xcorr_done,
  output logic                 frame_busy,
  output logic                 frame_drop
);
  localparam logic signed [NW+1:0] IDX_N = (NW+2)'(N);

  logic signed [DW-1:0] buf_a [2][N];
  logic signed [DW-1:0] buf_b [2][N];
  buf_flag_t            flag_q [2];
  logic                 tag_q [2];      // frame sequence tag per buffer
  logic                 wr_seq_q, rd_seq_q;
  logic [NW-1:0]        cnt_q;
  logic                 cap_active_q, cap_buf_q;
  logic                 drop_q;

  state_t               state_q;
  logic                 cur_q;
  logic signed [KW-1:0] k_q;
  logic [NW-1:0]        n_q;
  logic                 flush_q;

  // Capture-side decisions.
  logic freeing, free0, free1, claim_ok, claim_idx, cap_now, wr_buf, wr_en;
  // Compute-side decisions.
  logic any_full, take_sel;
  logic signed [NW+1:0] idx;
  logic signed [DW-1:0] rd_a, rd_b;

  // The buffer released by the last EMIT is claimable in that same cycle.
  assign freeing   = (state_q == ST_EMIT) && (k_q == KW'(MAX_LAG));
  assign free0     = (flag_q[0] == BUF_FREE) || (freeing && !cur_q);
  assign free1     = (flag_q[1] == BUF_FREE) || (freeing && cur_q);
  assign claim_ok  = free0 || free1;
  assign claim_idx = !free0;
  assign cap_now   = (cnt_q == '0) ? claim_ok : cap_active_q;
  assign wr_buf    = (cnt_q == '0) ? claim_idx : cap_buf_q;
  assign wr_en     = rst_n && pcm_valid && cap_now;

  // Oldest FULL buffer: at most one tag matches the read sequence.
  assign any_full = (flag_q[0] == BUF_FULL) || (flag_q[1] == BUF_FULL);
  assign take_sel = !((flag_q[0] == BUF_FULL) &&
                      ((flag_q[1] != BUF_FULL) || (tag_q[0] == rd_seq_q)));

  assign idx = $signed({2'b00, n_q}) + (NW+2)'(k_q);

  always_comb begin
    rd_a = buf_a[cur_q][n_q];
    rd_b = '0;
    // Terms with n+k outside the frame contribute zero.
    if (idx >= 0 && idx < IDX_N) rd_b = buf_b[cur_q][idx[NW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_a[wr_buf][cnt_q] <= pcm_a;
      buf_b[wr_buf][cnt_q] <= pcm_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_q[0]    <= BUF_FREE;
      flag_q[1]    <= BUF_FREE;
      tag_q[0]     <= 1'b0;
      tag_q[1]     <= 1'b0;
      wr_seq_q     <= 1'b0;
      rd_seq_q     <= 1'b0;
      cnt_q        <= '0;
      cap_active_q <= 1'b0;
      cap_buf_q    <= 1'b0;
      drop_q       <= 1'b0;
      state_q      <= ST_IDLE;
      cur_q        <= 1'b0;
      k_q          <= '0;
      n_q          <= '0;
      flush_q      <= 1'b0;
    end else begin
      // Capture: the counter always advances, even for dropped frames.
      drop_q <= 1'b0;
      if (pcm_valid) begin
        cnt_q <= cnt_q + NW'(1);
        if (cnt_q == '0) begin
          cap_active_q <= claim_ok;
          cap_buf_q    <= claim_idx;
          drop_q       <= !claim_ok;
        end
        if (cnt_q == NW'(N-1) && cap_now) begin
          flag_q[wr_buf] <= BUF_FULL;
          tag_q[wr_buf]  <= wr_seq_q;
          wr_seq_q       <= !wr_seq_q;
          cap_active_q   <= 1'b0;
        end
      end

      // Compute FSM.
      case (state_q)
        ST_IDLE: begin
          if (any_full) begin
            cur_q            <= take_sel;
            flag_q[take_sel] <= BUF_BUSY;
            rd_seq_q         <= !rd_seq_q;
            state_q          <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          k_q     <= KW'(-MAX_LAG);
          n_q     <= '0;
          state_q <= ST_MAC;
        end
        ST_MAC: begin
          n_q <= n_q + NW'(1);
          if (n_q == NW'(N-1)) begin
            flush_q <= 1'b0;
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) state_q <= ST_EMIT;
        end
        ST_EMIT: begin
          if (k_q == KW'(MAX_LAG)) begin
            flag_q[cur_q] <= BUF_FREE;
            state_q       <= ST_IDLE;
          end else begin
            k_q     <= k_q + KW'(1);
            n_q     <= '0;
            state_q <= ST_MAC;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  xcorr_mac #(.OUT_SHIFT(OUT_SHIFT)) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       ((state_q == ST_LOAD) || (state_q == ST_EMIT)),
    .in_valid  (state_q == ST_MAC),
    .a         (rd_a),
    .b         (rd_b),
    .emit      (state_q == ST_EMIT),
    .out_data  (xcorr_data),
    .out_valid (xcorr_done)
  );

  assign frame_busy = (state_q != ST_IDLE);
  assign frame_drop = drop_q;
endmodule

// File: tb/tb_gcc_xcorr_engine.sv
// Bench for gcc_xcorr_engine: two instances (OUT_SHIFT=0 and 6) share the
// same PCM stream; a reference correlation model fills expected queues.
module tb_gcc_xcorr_engine;
  import gcc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic signed [DW-1:0] pcm_a, pcm_b;
  logic                 pcm_valid;
  logic [OW-1:0]        xd0, xd6;
  logic                 done0, done6, busy0, busy6, drop0, drop6;

  gcc_xcorr_engine #(.OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pcm_a(pcm_a), .pcm_b(pcm_b), .pcm_valid(pcm_valid),
    .xcorr_data(xd0), .xcorr_done(done0), .frame_busy(busy0), .frame_drop(drop0)
  );

  gcc_xcorr_engine #(.OUT_SHIFT(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .pcm_a(pcm_a), .pcm_b(pcm_b), .pcm_valid(pcm_valid),
    .xcorr_data(xd6), .xcorr_done(done6), .frame_busy(busy6), .frame_drop(drop6)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic signed [DW-1:0] fa [N];
  logic signed [DW-1:0] fb [N];
  logic [OW-1:0] exp_q0[$];
  logic [OW-1:0] exp_q6[$];

  function automatic logic [OW-1:0] model_lag(input int k, input int sh);
    longint acc = 0;
    for (int n = 0; n < N; n++)
      if (n + k >= 0 && n + k < N) acc += longint'(fa[n]) * longint'(fb[n+k]);
    acc = acc >>> sh;
    if (acc > 64'sd2147483647) return 32'h7fff_ffff;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
    return acc[OW-1:0];
  endfunction

  task automatic push_frame();
    for (int k = -MAX_LAG; k <= MAX_LAG; k++) begin
      exp_q0.push_back(model_lag(k, 0));
      exp_q6.push_back(model_lag(k, 6));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int done_cnt0 = 0, done_cnt6 = 0, base0 = 0, base6 = 0;
  int drop_cnt = 0, drop_base = 0;
  int rise_cyc = 0, last_cyc = 0;
  logic busy_prev = 1'b0;
  logic [OW-1:0] vals0 [L];
  logic [OW-1:0] vals6 [L];

  always @(negedge clk) begin
    int s0, s6;
    if (busy0 && !busy_prev) rise_cyc = cyc;
    busy_prev = busy0;
    if (drop0) drop_cnt++;
    if (done0) begin
      s0 = (done_cnt0 - base0) % L;
      check("strobe0 expected", 64'(exp_q0.size() != 0), 1);
      if (exp_q0.size() != 0) check($sformatf("data0[%0d]", s0), xd0, exp_q0.pop_front());
      if (s0 == 0) check("first strobe latency", cyc - rise_cyc, 68);
      else check("lag cadence", cyc - last_cyc, 67);
      vals0[s0] = xd0;
      last_cyc = cyc;
      done_cnt0++;
    end
    if (done6) begin
      s6 = (done_cnt6 - base6) % L;
      check("strobe6 expected", 64'(exp_q6.size() != 0), 1);
      if (exp_q6.size() != 0) check($sformatf("data6[%0d]", s6), xd6, exp_q6.pop_front());
      vals6[s6] = xd6;
      done_cnt6++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_const(input int av, input int bv);
    for (int i = 0; i < N; i++) begin
      fa[i] = DW'(av);
      fb[i] = DW'(bv);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      fa[i] = DW'($urandom_range(0, 65535));
      fb[i] = DW'($urandom_range(0, 65535));
    end
  endtask

  // Drives one frame back-to-back; leaves pcm_valid high for chaining.
  task automatic send_frame(input bit expect_drop);
    if (!expect_drop) push_frame();
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      pcm_valid = 1'b1;
      pcm_a     = fa[i];
      pcm_b     = fb[i];
      if (i == 1) begin
        @(negedge clk);
        check("frame_drop0", drop0, expect_drop);
        check("frame_drop6", drop6, expect_drop);
      end
    end
  endtask

  task automatic end_stream();
    @(posedge clk); #1;
    pcm_valid = 1'b0;
    pcm_a     = '0;
    pcm_b     = '0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((exp_q0.size() != 0 || exp_q6.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("drain left", exp_q0.size() + exp_q6.size(), 0);
    repeat (3) @(negedge clk);
    check("busy after drain", {busy0, busy6}, 2'b00);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " data0"}, xd0, 0);
    check({tag, " data6"}, xd6, 0);
    check({tag, " ctl"}, {done0, busy0, drop0, done6, busy6, drop6}, 6'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int cnt_before;
    rst_n = 1'b0; pcm_valid = 1'b0; pcm_a = '0; pcm_b = '0;
    repeat (2) @(posedge clk);
    #1 pcm_valid = 1'b1; pcm_a = 16'sd5; pcm_b = 16'sd7;   // ignored during reset
    @(posedge clk); #1 pcm_valid = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Impulse: only k=+3 is nonzero.
    fill_const(0, 0); fa[10] = 16'sd1000; fb[13] = 16'sd1000;
    send_frame(0); end_stream(); wait_drain(5000);
    check("impulse k=+3", vals0[19], 1000000);
    check("impulse k=0", vals0[16], 0);

    // Constant: r[k] = 10000*(64-|k|).
    fill_const(100, 100);
    send_frame(0); end_stream(); wait_drain(5000);
    check("const k=-16", vals0[0], 480000);
    check("const k=0", vals0[16], 640000);
    check("const k=+16", vals0[32], 480000);

    // Positive and negative saturation.
    fill_const(32767, 32767);
    send_frame(0); end_stream(); wait_drain(5000);
    check("sat+ k=0", vals0[16], 32'h7fff_ffff);
    check("sat+ shift6 k=0", vals6[16], 1073676289);
    fill_const(32767, -32768);
    send_frame(0); end_stream(); wait_drain(5000);
    check("sat- k=-16", vals0[0], 32'h8000_0000);

    // Overrun: three back-to-back frames, third is dropped.
    drop_base = drop_cnt;
    fill_rand(); send_frame(0);
    fill_rand(); send_frame(0);
    fill_rand(); send_frame(1);
    end_stream(); wait_drain(10000);
    check("drop pulses", drop_cnt - drop_base, 1);
    repeat (20) @(negedge clk);
    fill_rand(); send_frame(0); end_stream(); wait_drain(5000);

    // Reset after strobe #5 aborts the lag sequence.
    fill_rand(); send_frame(0); end_stream();
    cnt_before = done_cnt0;
    c = 0;
    while (done_cnt0 - cnt_before < 6 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("strobes before reset", done_cnt0 - cnt_before, 6);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q0.delete(); exp_q6.delete();
    base0 = done_cnt0; base6 = done_cnt6;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid reset");
    cnt_before = done_cnt0;
    repeat (300) @(negedge clk);
    check("no strobes after reset", done_cnt0 - cnt_before, 0);
    check("idle after reset", busy0, 0);

    fill_rand(); send_frame(0); end_stream(); wait_drain(5000);
    check("fresh frame strobes", done_cnt0 - cnt_before, L);
    check("fresh frame strobes6", done_cnt6 - base6, L);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
